// File: rtl/axi_tester_pkg.sv
// Shared definitions for the AXI4 memory tester: AXI encodings, test modes,
// FSM state encoding and the burst-size helper.
package axi_tester_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] MODE_WRITE  = 2'd0;
  localparam logic [1:0] MODE_READ   = 2'd1;
  localparam logic [1:0] MODE_VERIFY = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WADDR, ST_WDATA, ST_WRESP, ST_RADDR, ST_RDATA, ST_DONE
  } state_t;

  function automatic int bytes_per_burst(input int burst_len, input int data_width);
    return burst_len * data_width / 8;
  endfunction

endpackage

// File: rtl/axi_tester_pattern.sv
// Address-derived test pattern: every 32-bit lane i of the data word is
// beat_addr[31:0] ^ seed ^ i. Used both to generate write data and to
// produce the expected read data.
//   beat_addr  in   byte address of the beat
//   seed       in   run seed
//   pattern    out  DATA_W-bit expected word
module axi_tester_pattern #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] beat_addr,
  input  logic [31:0]       seed,
  output logic [DATA_W-1:0] pattern
);
  localparam int LANES = DATA_W / 32;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pattern[i*32 +: 32] = beat_addr[31:0] ^ seed ^ 32'(i);
  end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 master traffic generator / memory checker. Sweeps
// [C_START_ADDR, C_END_ADDR) with INCR bursts in write-only, read-only or
// write-then-verify mode, checks read data against the address pattern and
// counts errors. One transaction outstanding at a time.
//   clk, reset_n     clock, async active-low reset
//   start/stop/mode/seed  control (mode, seed sampled at start)
//   busy, done, err_count, pass_count, first_err_addr  status
//   M_axi_*          AXI4 master port
module axi_mem_tester
  import axi_tester_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_BURST_LEN  = 8,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_START_ADDR = 32'h0100_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_END_ADDR   = 32'h1000_0000,
  parameter int C_PASSES = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic [1:0]                      mode,
  input  logic [31:0]                     seed,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     err_count,
  output logic [15:0]                     pass_count,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
  output logic [7:0]                      M_axi_awlen,
  output logic [2:0]                      M_axi_awsize,
  output logic [1:0]                      M_axi_awburst,
  output logic                            M_axi_awlock,
  output logic [3:0]                      M_axi_awcache,
  output logic [2:0]                      M_axi_awprot,
  output logic [3:0]                      M_axi_awqos,
  output logic                            M_axi_awvalid,
  input  logic                            M_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
  output logic                            M_axi_wlast,
  output logic                            M_axi_wvalid,
  input  logic                            M_axi_wready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_bid,
  input  logic [1:0]                      M_axi_bresp,
  input  logic                            M_axi_bvalid,
  output logic                            M_axi_bready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_araddr,
  output logic [7:0]                      M_axi_arlen,
  output logic [2:0]                      M_axi_arsize,
  output logic [1:0]                      M_axi_arburst,
  output logic                            M_axi_arlock,
  output logic [3:0]                      M_axi_arcache,
  output logic [2:0]                      M_axi_arprot,
  output logic [3:0]                      M_axi_arqos,
  output logic                            M_axi_arvalid,
  input  logic                            M_axi_arready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_rdata,
  input  logic [1:0]                      M_axi_rresp,
  input  logic                            M_axi_rlast,
  input  logic                            M_axi_rvalid,
  output logic                            M_axi_rready
);
  localparam int AW         = C_S_AXI_ADDR_WIDTH;
  localparam int DW         = C_S_AXI_DATA_WIDTH;
  localparam int BEAT_BYTES = DW / 8;
  localparam int STEP       = bytes_per_burst(C_S_AXI_BURST_LEN, DW);
  localparam int BW         = (C_S_AXI_BURST_LEN > 1) ? $clog2(C_S_AXI_BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(C_S_AXI_BURST_LEN - 1);

  state_t          state;
  logic [AW-1:0]   addr;
  logic [BW-1:0]   beat;
  logic [1:0]      mode_q;
  logic [31:0]     seed_q;
  logic            stop_req;
  logic [AW-1:0]   beat_addr;
  logic [DW-1:0]   expected;
  logic [AW:0]     next_addr;
  logic [15:0]     pass_inc;
  logic [AW-1:0]   err_addr;
  logic phase_end, in_wr, rd_beat, burst_end, sweep_done, finish, next_read, err_hit;

  // IDs are fixed per direction, so responses need no ID matching.
  logic unused_ids;
  assign unused_ids = ^{M_axi_bid, M_axi_rid};

  assign M_axi_awid    = '0;
  assign M_axi_arid    = C_S_AXI_ID_WIDTH'(1);
  assign M_axi_awaddr  = addr;
  assign M_axi_araddr  = addr;
  assign M_axi_awlen   = 8'(C_S_AXI_BURST_LEN - 1);
  assign M_axi_arlen   = 8'(C_S_AXI_BURST_LEN - 1);
  assign M_axi_awsize  = 3'($clog2(BEAT_BYTES));
  assign M_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign M_axi_awburst = AXI_BURST_INCR;
  assign M_axi_arburst = AXI_BURST_INCR;
  assign M_axi_awlock  = 1'b0;
  assign M_axi_arlock  = 1'b0;
  assign M_axi_awcache = 4'b0011;
  assign M_axi_arcache = 4'b0011;
  assign M_axi_awprot  = '0;
  assign M_axi_arprot  = '0;
  assign M_axi_awqos   = '0;
  assign M_axi_arqos   = '0;
  assign M_axi_wstrb   = '1;

  // One pattern generator serves both directions; beat only advances on a
  // handshake, so wdata is stable while the slave stalls.
  assign beat_addr = addr + AW'(beat) * AW'(BEAT_BYTES);

  axi_tester_pattern #(.ADDR_W(AW), .DATA_W(DW)) u_pattern (
    .beat_addr (beat_addr),
    .seed      (seed_q),
    .pattern   (expected)
  );

  assign M_axi_wdata = expected;
  assign M_axi_wlast = M_axi_wvalid && (beat == LAST_BEAT);

  always_comb begin
    next_addr  = {1'b0, addr} + (AW+1)'(STEP);
    phase_end  = next_addr >= {1'b0, C_END_ADDR};
    in_wr      = (state == ST_WRESP);
    rd_beat    = (state == ST_RDATA) && M_axi_rvalid && M_axi_rready;
    burst_end  = (in_wr && M_axi_bvalid && M_axi_bready) || (rd_beat && M_axi_rlast);
    // A verify run only counts a pass at the end of its read phase.
    sweep_done = phase_end && !(in_wr && mode_q == MODE_VERIFY);
    pass_inc   = pass_count + 16'd1;
    finish     = stop_req || stop ||
                 (sweep_done && (C_PASSES != 0) && (pass_inc == 16'(C_PASSES)));
    case (mode_q)
      MODE_READ:   next_read = 1'b1;
      MODE_VERIFY: next_read = in_wr ? phase_end : !phase_end;
      default:     next_read = 1'b0;
    endcase
    err_hit  = (in_wr && M_axi_bvalid && M_axi_bready && M_axi_bresp != AXI_RESP_OKAY) ||
               (rd_beat && (M_axi_rdata != expected || M_axi_rresp != AXI_RESP_OKAY));
    err_addr = in_wr ? addr : beat_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      addr           <= C_START_ADDR;
      beat           <= '0;
      mode_q         <= MODE_WRITE;
      seed_q         <= '0;
      stop_req       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      pass_count     <= '0;
      first_err_addr <= '0;
      M_axi_awvalid  <= 1'b0;
      M_axi_wvalid   <= 1'b0;
      M_axi_bready   <= 1'b0;
      M_axi_arvalid  <= 1'b0;
      M_axi_rready   <= 1'b0;
    end else begin
      done <= 1'b0;
      // stop is remembered so a short pulse still ends the run at a burst boundary
      if (busy && stop) stop_req <= 1'b1;

      if (err_hit) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == '0)       first_err_addr <= err_addr;
      end

      case (state)
        ST_IDLE: if (start) begin
          busy           <= 1'b1;
          mode_q         <= mode;
          seed_q         <= seed;
          stop_req       <= stop;
          addr           <= C_START_ADDR;
          beat           <= '0;
          err_count      <= '0;
          pass_count     <= '0;
          first_err_addr <= '0;
          if (mode == MODE_READ) begin
            state <= ST_RADDR; M_axi_arvalid <= 1'b1;
          end else begin
            state <= ST_WADDR; M_axi_awvalid <= 1'b1;
          end
        end
        ST_WADDR: if (M_axi_awready) begin
          M_axi_awvalid <= 1'b0;
          M_axi_wvalid  <= 1'b1;
          state         <= ST_WDATA;
        end
        ST_WDATA: if (M_axi_wready) begin
          if (beat == LAST_BEAT) begin
            beat         <= '0;
            M_axi_wvalid <= 1'b0;
            M_axi_bready <= 1'b1;
            state        <= ST_WRESP;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        ST_WRESP: if (M_axi_bvalid) M_axi_bready <= 1'b0;
        ST_RADDR: if (M_axi_arready) begin
          M_axi_arvalid <= 1'b0;
          M_axi_rready  <= 1'b1;
          state         <= ST_RDATA;
        end
        ST_RDATA: if (rd_beat) begin
          beat <= beat + BW'(1);
          if (M_axi_rlast) begin
            beat         <= '0;
            M_axi_rready <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Burst boundary: advance/wrap the address and pick the next phase.
      if (burst_end) begin
        addr <= phase_end ? C_START_ADDR : next_addr[AW-1:0];
        if (sweep_done) pass_count <= pass_inc;
        if (finish) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (next_read) begin
          state <= ST_RADDR; M_axi_arvalid <= 1'b1;
        end else begin
          state <= ST_WADDR; M_axi_awvalid <= 1'b1;
        end
      end
    end
  end

endmodule
